// File: rtl/timer_dev.sv
// Memory-mapped countdown timer on the M-stage data bus: CTRL / PRESET / COUNT
// registers, a four-state counting FSM and a maskable interrupt request.
module timer_dev #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic        write_enable,
  input  logic [31:0] write_data,
  output logic [31:0] read_result,
  output logic        irq
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CNT  = 2'd2,
    INT  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    REG_CTRL   = 2'd0,
    REG_PRESET = 2'd1,
    REG_COUNT  = 2'd2,
    REG_NONE   = 2'd3
  } reg_sel_t;

  state_t      state;
  logic [3:0]  ctrl;
  logic [31:0] preset;
  logic [31:0] count;
  logic        irq_flag;

  logic        hit;
  reg_sel_t    sel;
  logic        wr_ctrl;
  logic        wr_preset;
  logic        en;
  logic        auto_reload;

  assign hit         = (addr[31:4] == BASE_ADDR[31:4]) && (addr[1:0] == 2'b00);
  assign sel         = reg_sel_t'(addr[3:2]);
  assign wr_ctrl     = write_enable && hit && (sel == REG_CTRL);
  assign wr_preset   = write_enable && hit && (sel == REG_PRESET);
  assign en          = ctrl[0];
  // MODE 1x falls back to one-shot, so only the exact 01 pattern reloads.
  assign auto_reload = (ctrl[2:1] == 2'b01);

  assign irq = irq_flag & ctrl[3];

  // NOTE: every signal assigned in always_comb gets a default first so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    read_result = '0;
    if (hit) begin
      case (sel)
        REG_CTRL:   read_result = {28'd0, ctrl};
        REG_PRESET: read_result = preset;
        REG_COUNT:  read_result = count;
        default:    read_result = '0;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every branch
  // below sees pre-edge values, which is what the collision rules rely on.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      ctrl     <= '0;
      preset   <= '0;
      count    <= '0;
      irq_flag <= 1'b0;
    end else begin
      if (wr_preset) preset <= write_data;

      case (state)
        IDLE: if (en) state <= LOAD;
        LOAD: begin
          count <= preset;
          state <= CNT;
        end
        CNT: begin
          if (!en) begin
            state <= IDLE;
          end else if (count == 32'd0) begin
            state    <= INT;
            irq_flag <= 1'b1;
          end else begin
            count <= count - 32'd1;
          end
        end
        INT: begin
          if (auto_reload) begin
            irq_flag <= 1'b0;
            state    <= LOAD;
          end else begin
            ctrl[0] <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      // Later assignments override the FSM: a CPU write beats the one-shot
      // EN auto-clear and any flag set or clear made in the same edge.
      if (wr_ctrl) ctrl <= write_data[3:0];
      if (wr_ctrl || wr_preset) irq_flag <= 1'b0;
    end
  end

endmodule

// File: tb/tb_timer_dev.sv
// Directed self-checking bench for timer_dev: reset, one-shot, auto-reload,
// mid-count disable, write/INT collision and address decode.
module tb_timer_dev;

  localparam logic [31:0] BASE   = 32'h0000_7F00;
  localparam logic [31:0] A_CTRL = BASE + 32'd0;
  localparam logic [31:0] A_PRE  = BASE + 32'd4;
  localparam logic [31:0] A_CNT  = BASE + 32'd8;
  localparam logic [31:0] A_RSV  = BASE + 32'd12;

  logic        clk;
  logic        rst;
  logic [31:0] addr;
  logic        write_enable;
  logic [31:0] write_data;
  logic [31:0] read_result;
  logic        irq;

  int total;
  int bad;

  timer_dev #(.BASE_ADDR(BASE)) dut (
    .clk          (clk),
    .rst          (rst),
    .addr         (addr),
    .write_enable (write_enable),
    .write_data   (write_data),
    .read_result  (read_result),
    .irq          (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Store takes effect on the next rising edge; returns 1 unit after it.
  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    addr         = a;
    write_data   = d;
    write_enable = 1'b1;
    @(posedge clk);
    #1;
    write_enable = 1'b0;
    write_data   = '0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    addr = a;
    #1;
    d = read_result;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    apply_reset();
    total++;
    if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq: got %b want 0", irq); end
    bus_read(A_CTRL, d);
    total++;
    if (d !== 32'd0) begin bad++; $display("FAIL reset_ctrl: got %h want 0", d); end

    // Start a count, then hit rst mid-CNT with no clock edge.
    bus_write(A_PRE, 32'd5);
    bus_write(A_CTRL, 32'h9);
    tick(); tick(); tick();
    bus_read(A_CNT, d);
    total++;
    if (d !== 32'd4) begin bad++; $display("FAIL pre_reset_count: got %0d want 4", d); end
    rst = 1'b1;
    #1;
    total++;
    if (irq !== 1'b0) begin bad++; $display("FAIL async_reset_irq: got %b want 0", irq); end
    bus_read(A_CNT, d);
    total++;
    if (d !== 32'd0) begin bad++; $display("FAIL async_reset_count: got %h want 0", d); end
    bus_read(A_CTRL, d);
    total++;
    if (d !== 32'd0) begin bad++; $display("FAIL async_reset_ctrl: got %h want 0", d); end
    bus_read(A_PRE, d);
    total++;
    if (d !== 32'd0) begin bad++; $display("FAIL async_reset_preset: got %h want 0", d); end
    @(negedge clk);
    rst = 1'b0;
    tick(); tick(); tick();
    bus_read(A_CNT, d);
    total++;
    if (d !== 32'd0) begin bad++; $display("FAIL post_reset_idle: got %h want 0", d); end
  endtask

  task automatic test_one_shot();
    logic [31:0] d;
    logic [31:0] exp_cnt [4];
    exp_cnt = '{32'd3, 32'd2, 32'd1, 32'd0};
    apply_reset();
    bus_write(A_PRE, 32'd3);
    bus_write(A_CTRL, 32'h9);        // edge 0
    tick();                          // edge 1: LOAD
    for (int i = 0; i < 4; i++) begin
      tick();                        // edges 2..5
      bus_read(A_CNT, d);
      total++;
      if (d !== exp_cnt[i]) begin bad++; $display("FAIL oneshot_count[%0d]: got %0d want %0d", i, d, exp_cnt[i]); end
      total++;
      if (irq !== 1'b0) begin bad++; $display("FAIL oneshot_irq_early[%0d]: got %b want 0", i, irq); end
    end
    tick();                          // edge 6: INT
    total++;
    if (irq !== 1'b1) begin bad++; $display("FAIL oneshot_irq_rise: got %b want 1", irq); end
    tick();                          // edge 7: IDLE, EN cleared
    bus_read(A_CTRL, d);
    total++;
    if (d !== 32'h8) begin bad++; $display("FAIL oneshot_ctrl_after: got %h want 8", d); end
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (irq !== 1'b1) begin bad++; $display("FAIL oneshot_irq_hold[%0d]: got %b want 1", i, irq); end
    end
    bus_write(A_CTRL, 32'h0);
    total++;
    if (irq !== 1'b0) begin bad++; $display("FAIL oneshot_irq_clear: got %b want 0", irq); end
  endtask

  task automatic test_auto_reload();
    logic exp;
    apply_reset();
    bus_write(A_PRE, 32'd2);
    bus_write(A_CTRL, 32'hB);        // edge 0; period N+3 = 5
    for (int k = 1; k <= 20; k++) begin
      tick();
      exp = ((k % 5) == 0);
      total++;
      if (irq !== exp) begin bad++; $display("FAIL reload_irq[edge %0d]: got %b want %b", k, irq, exp); end
    end
  endtask

  task automatic test_mid_count_disable();
    logic [31:0] d;
    apply_reset();
    bus_write(A_PRE, 32'd10);
    bus_write(A_CTRL, 32'h9);        // edge 0
    tick(); tick(); tick(); tick();  // edges 1..4, COUNT = 8
    bus_write(A_CTRL, 32'h0);        // edge 5: last decrement to 7
    for (int i = 0; i < 4; i++) begin
      tick();
      bus_read(A_CNT, d);
      total++;
      if (d !== 32'd7) begin bad++; $display("FAIL disable_count[%0d]: got %0d want 7", i, d); end
      total++;
      if (irq !== 1'b0) begin bad++; $display("FAIL disable_irq[%0d]: got %b want 0", i, irq); end
    end
  endtask

  task automatic test_collision();
    logic [31:0] d;
    apply_reset();
    bus_write(A_PRE, 32'd1);
    bus_write(A_CTRL, 32'h9);        // edge 0; INT reached at edge 4
    tick(); tick(); tick(); tick();
    total++;
    if (irq !== 1'b1) begin bad++; $display("FAIL collide_irq_before: got %b want 1", irq); end
    bus_write(A_CTRL, 32'hB);        // edge 5: leaves INT
    bus_read(A_CTRL, d);
    total++;
    if (d !== 32'hB) begin bad++; $display("FAIL collide_ctrl: got %h want b", d); end
    total++;
    if (irq !== 1'b0) begin bad++; $display("FAIL collide_irq: got %b want 0", irq); end
    tick(); tick();                  // edge 6 LOAD, edge 7 CNT
    bus_read(A_CNT, d);
    total++;
    if (d !== 32'd1) begin bad++; $display("FAIL collide_restart_count: got %0d want 1", d); end
    tick(); tick();                  // edge 9: INT again
    total++;
    if (irq !== 1'b1) begin bad++; $display("FAIL collide_restart_irq: got %b want 1", irq); end
  endtask

  task automatic test_decode();
    logic [31:0] d;
    apply_reset();
    bus_write(A_CNT, 32'h1234_5678);
    bus_read(A_CNT, d);
    total++;
    if (d !== 32'd0) begin bad++; $display("FAIL decode_count_ro: got %h want 0", d); end
    bus_write(BASE + 32'd1, 32'hF);
    bus_read(A_CTRL, d);
    total++;
    if (d !== 32'd0) begin bad++; $display("FAIL decode_misaligned: got %h want 0", d); end
    bus_write(BASE + 32'd16, 32'hF);
    bus_read(A_CTRL, d);
    total++;
    if (d !== 32'd0) begin bad++; $display("FAIL decode_out_of_window: got %h want 0", d); end
    bus_write(A_RSV, 32'hDEAD_BEEF);
    bus_read(A_RSV, d);
    total++;
    if (d !== 32'd0) begin bad++; $display("FAIL decode_reserved: got %h want 0", d); end
    bus_write(A_PRE, 32'hA5A5_0003);
    bus_read(A_PRE, d);
    total++;
    if (d !== 32'hA5A5_0003) begin bad++; $display("FAIL decode_preset_rw: got %h want a5a50003", d); end
    bus_read(BASE + 32'd5, d);
    total++;
    if (d !== 32'd0) begin bad++; $display("FAIL decode_misaligned_read: got %h want 0", d); end
    bus_write(A_CTRL, 32'hFFFF_FFFF);
    bus_read(A_CTRL, d);
    total++;
    if (d !== 32'h0000_000F) begin bad++; $display("FAIL decode_ctrl_width: got %h want 0000000f", d); end
  endtask

  initial begin
    total        = 0;
    bad          = 0;
    rst          = 1'b1;
    addr         = '0;
    write_enable = 1'b0;
    write_data   = '0;
    test_reset();
    test_one_shot();
    test_auto_reload();
    test_mid_count_disable();
    test_collision();
    test_decode();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
